// File: rtl/imem_pkg.sv
// Shared types for the instruction memory fetch unit: response error codes,
// output-register states and the default NOP word.
package imem_pkg;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_RANGE    = 2'd2,
        ERR_PARITY   = 2'd3
    } imem_err_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_e;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/imem_array.sv
// Single-port instruction storage with registered read and write priority.
// With IMEM_PARITY_EN defined, an even-parity bit is stored alongside each word.
module imem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 1024,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              par_err_o
);

`ifdef IMEM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    logic [MEM_W-1:0] mem_q [DEPTH];
    logic [MEM_W-1:0] rd_q;
    logic [MEM_W-1:0] wword;

`ifdef IMEM_PARITY_EN
    assign wword = {^wdata_i, wdata_i};
`else
    assign wword = wdata_i;
`endif

    // Storage has no reset so it maps onto RAM; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wword;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q <= '0;
        end else if (re_i && !we_i) begin
            rd_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rd_q[DATA_W-1:0];

`ifdef IMEM_PARITY_EN
    assign par_err_o = ^rd_q;
`else
    assign par_err_o = 1'b0;
`endif

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction fetch unit: valid/ready request/response around imem_array, with
// loader port, branch flush and error reporting. Parity option: IMEM_PARITY_EN.
module imem_fetch_unit
    import imem_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 1024,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT),
    localparam int unsigned      AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic [1:0]        rsp_err,
    input  logic              flush,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              perr_stky
);

    rsp_state_e  state_q, state_d;
    imem_err_e   err_q, err_d;
    imem_err_e   req_err;
    logic        accept;
    logic        misalign;
    logic        out_of_range;
    logic        arr_par_err;
    logic        par_hit;
    logic [DATA_W-1:0] arr_rdata;

    assign rsp_valid = (state_q == ST_FULL);
    assign req_ready = !reset && !prog_we && !flush && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;

    assign misalign     = |(req_addr & ADDR_W'((DATA_W / 8) - 1));
    assign out_of_range = (req_addr >> 2) >= ADDR_W'(DEPTH);

    always_comb begin
        req_err = ERR_OK;
        if (misalign) begin
            req_err = ERR_MISALIGN;
        end else if (out_of_range) begin
            req_err = ERR_RANGE;
        end
    end

    imem_array #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i    (clk),
        .rst_i    (reset),
        .we_i     (prog_we && !reset),
        .waddr_i  (prog_addr),
        .wdata_i  (prog_data),
        .re_i     (accept),
        .raddr_i  (req_addr[2 +: AW]),
        .rdata_o  (arr_rdata),
        .par_err_o(arr_par_err)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_d = ST_FULL;
                ST_FULL: begin
                    if (accept)         state_d = ST_FULL;
                    else if (rsp_ready) state_d = ST_EMPTY;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        if (accept) begin
            err_d = req_err;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Parity is only known once the word leaves the array, so it is folded in here.
    assign par_hit   = rsp_valid && (err_q == ERR_OK) && arr_par_err;
    assign rsp_err   = par_hit ? ERR_PARITY : err_q;
    assign rsp_instr = (rsp_err != ERR_OK) ? NOP_WORD : arr_rdata;

`ifdef IMEM_PARITY_EN
    logic perr_stky_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            perr_stky_q <= 1'b0;
        end else if (par_hit) begin
            perr_stky_q <= 1'b1;
        end
    end
    assign perr_stky = perr_stky_q;
`else
    assign perr_stky = 1'b0;
`endif

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit with an expected-response scoreboard queue.
module tb_imem_fetch_unit;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  err;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_instr;
    logic [1:0]        rsp_err;
    logic              flush;
    logic              prog_we;
    logic [AW-1:0]     prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              perr_stky;

    exp_t        sbq[$];
    logic [31:0] model [DEPTH];
    logic        bad   [DEPTH];
    int          checks = 0;
    int          failures = 0;
    int          ndeliv = 0;
    int          nexp_deliv = 0;

    always #5 clk = ~clk;

    imem_fetch_unit #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .NOP_WORD(NOP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr),
        .rsp_err  (rsp_err),
        .flush    (flush),
        .prog_we  (prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .perr_stky(perr_stky)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t predict(input logic [ADDR_W-1:0] a);
        exp_t e;
        if (a[1:0] != 2'b00) begin
            e.instr = NOP; e.err = 2'd1;
        end else if ((a >> 2) >= DEPTH) begin
            e.instr = NOP; e.err = 2'd2;
        end else if (bad[a[2 +: AW]]) begin
            e.instr = NOP; e.err = 2'd3;
        end else begin
            e.instr = model[a[2 +: AW]]; e.err = 2'd0;
        end
        return e;
    endfunction

    // One clock: settle, score the current cycle's handshakes, then advance.
    task automatic cycle();
        exp_t e;
        #1;
        if (reset) begin
            sbq.delete();
        end else begin
            if (flush && rsp_valid) begin
                if (sbq.size() > 0) void'(sbq.pop_front());
            end else if (rsp_valid && rsp_ready) begin
                if (sbq.size() == 0) begin
                    check("unexpected_rsp", 64'(rsp_valid), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    check("rsp_instr", 64'(rsp_instr), 64'(e.instr));
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                    ndeliv++;
                end
            end
            if (req_valid && req_ready) sbq.push_back(predict(req_addr));
            if (prog_we) begin
                model[prog_addr] = prog_data;
                bad[prog_addr]   = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = 'x;
            bad[i]   = 1'b0;
        end
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        flush = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        req_valid = 1'b1;
        cycle(); cycle();
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_instr", 64'(rsp_instr), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_perr_stky", 64'(perr_stky), 64'd0);
        reset = 1'b0; req_valid = 1'b0;
        cycle();

        // Test 1: program and back-to-back fetch
        for (int i = 0; i < 4; i++) begin
            prog_we = 1'b1; prog_addr = AW'(i); prog_data = 32'hA0 + 32'(i);
            cycle();
        end
        prog_we = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_addr = 32'(i * 4);
            #1;
            if (i > 0) check("t1_consec_valid", 64'(rsp_valid), 64'd1);
            check("t1_req_ready", 64'(req_ready), 64'd1);
            cycle();
        end
        req_valid = 1'b0;
        #1;
        check("t1_last_valid", 64'(rsp_valid), 64'd1);
        cycle();
        nexp_deliv += 4;

        // Test 2: stall holds the response
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h4;
        cycle();
        req_addr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2_valid_held", 64'(rsp_valid), 64'd1);
            check("t2_instr_stable", 64'(rsp_instr), 64'hA1);
            check("t2_req_ready", 64'(req_ready), 64'd0);
            cycle();
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        cycle();
        nexp_deliv += 1;

        // Test 3: misaligned and out-of-range requests
        req_valid = 1'b1; req_addr = 32'h6;
        cycle();
        req_addr = 32'(DEPTH * 4);
        cycle();
        req_valid = 1'b0;
        #1;
        check("t3_range_err", 64'(rsp_err), 64'd2);
        check("t3_range_nop", 64'(rsp_instr), 64'(NOP));
        cycle();
        nexp_deliv += 2;

        // Test 4: flush drops the pending response
        req_valid = 1'b1; req_addr = 32'h8;
        cycle();
        flush = 1'b1;
        #1;
        check("t4_flush_req_ready", 64'(req_ready), 64'd0);
        cycle();
        flush = 1'b0; req_valid = 1'b0;
        #1;
        check("t4_after_flush_valid", 64'(rsp_valid), 64'd0);
        check("t4_queue_empty", 64'(sbq.size()), 64'd0);
        cycle();

        // Test 5: loader write blocks fetch and is visible afterwards
        prog_we = 1'b1; prog_addr = AW'(2); prog_data = 32'hB2;
        req_valid = 1'b1; req_addr = 32'h8;
        #1;
        check("t5_prog_req_ready", 64'(req_ready), 64'd0);
        cycle();
        prog_we = 1'b0;
        cycle();
        req_valid = 1'b0;
        #1;
        check("t5_new_data", 64'(rsp_instr), 64'hB2);
        cycle();
        nexp_deliv += 1;

        // Reset mid-stall; loader write during reset is ignored
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
        cycle();
        req_valid = 1'b0;
        cycle();
        reset = 1'b1; prog_we = 1'b1; prog_addr = '0; prog_data = 32'hDEAD;
        cycle();
        reset = 1'b0; prog_we = 1'b0;
        #1;
        check("rst_drop_valid", 64'(rsp_valid), 64'd0);
        check("rst_drop_instr", 64'(rsp_instr), 64'd0);
        rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
        cycle();
        req_valid = 1'b0;
        #1;
        check("rst_prog_ignored", 64'(rsp_instr), 64'hA0);
        cycle();
        nexp_deliv += 1;

`ifdef IMEM_PARITY_EN
        // Test 6: corrupted stored bit reports parity error and sets the sticky flag
        prog_we = 1'b1; prog_addr = AW'(5); prog_data = 32'h55;
        cycle();
        prog_we = 1'b0;
        dut.u_array.mem_q[5] = dut.u_array.mem_q[5] ^ 33'h1;
        bad[5] = 1'b1;
        req_valid = 1'b1; req_addr = 32'h14;
        cycle();
        req_valid = 1'b0;
        cycle();
        nexp_deliv += 1;
        check("t6_stky_set", 64'(perr_stky), 64'd1);
        cycle();
        check("t6_stky_held", 64'(perr_stky), 64'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        #1;
        check("t6_stky_cleared", 64'(perr_stky), 64'd0);
`else
        check("perr_stky_tied", 64'(perr_stky), 64'd0);
`endif

        cycle();
        check("deliveries", 64'(ndeliv), 64'(nexp_deliv));
        check("final_queue_empty", 64'(sbq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
